mprj_io_serial_loader: RTL and testbench

Sequencer that programs the user-project I/O pad configuration chain from the management side. On a start request it fetches one configuration word per pad from a local register file, shifts each word serially into the pad control chain with a generated serial clock, then pulses the load strobe so every pad latches its new mode in one step. It sits in the housekeeping domain, between the pad configuration registers and the buffered management GPIO / pad control path.

---
 rtl/mprj_io_serial_loader.sv | 145 ++++++++++++++
 tb/tb_mprj_io_serial_loader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mprj_io_serial_loader.sv
// Serial loader for the user-project pad configuration chain.
// Fetches one config word per pad (highest pad first), shifts it MSB first
// with a generated serial clock, then strobes serial_load so all pads latch.
module mprj_io_serial_loader #(
    parameter int NUM_PADS = 19,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 1
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rstn_i,
    input  logic                        start,
    input  logic                        abort,
    output logic                        cfg_rd,
    output logic [$clog2(NUM_PADS)-1:0] cfg_idx,
    input  logic [CFG_BITS-1:0]         cfg_data,
    output logic                        serial_clock,
    output logic                        serial_data_out,
    output logic                        serial_load,
    output logic                        busy,
    output logic                        done
);

    // A divider of 0 would never let the timed states advance; clamp to 1.
    localparam int DIV = (CLK_DIV < 1) ? 1 : CLK_DIV;
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PW  = $clog2(NUM_PADS);
    localparam int BW  = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;

    localparam logic [DW-1:0] DIV_RELOAD = DW'(DIV - 1);
    localparam logic [PW-1:0] LAST_PAD   = PW'(NUM_PADS - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(CFG_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    state_t                state, state_nx;
    logic [PW-1:0]         pad_idx, pad_nx;
    logic [BW-1:0]         bit_cnt;
    logic [DW-1:0]         div_cnt;
    logic [CFG_BITS-1:0]   shreg;
    logic                  timed_entry;

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) state <= IDLE;
        else            state <= state_nx;
    end

    // Next-state and next pad index. Abort cancels any busy state except
    // DONE, which still completes its pulse.
    always_comb begin
        state_nx = state;
        pad_nx   = pad_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = FETCH;
                    pad_nx   = LAST_PAD;
                end
            end
            FETCH:    state_nx = CAPTURE;
            CAPTURE:  state_nx = SHIFT_LO;
            SHIFT_LO: if (div_cnt == '0) state_nx = SHIFT_HI;
            SHIFT_HI: begin
                if (div_cnt == '0) begin
                    if (bit_cnt != '0) begin
                        state_nx = SHIFT_LO;
                    end else if (pad_idx != '0) begin
                        state_nx = FETCH;
                        pad_nx   = pad_idx - 1'b1;
                    end else begin
                        state_nx = LOAD;
                    end
                end
            end
            LOAD:     if (div_cnt == '0) state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (abort && state != IDLE && state != DONE) begin
            state_nx = IDLE;
            pad_nx   = pad_idx;
        end
    end

    // Divider reload happens on every entry into a timed phase.
    assign timed_entry = (state_nx != state) &&
                         (state_nx == SHIFT_LO || state_nx == SHIFT_HI || state_nx == LOAD);

    // Datapath: pad index, divider, bit counter, shift register.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            pad_idx <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            pad_idx <= pad_nx;
            if (timed_entry)         div_cnt <= DIV_RELOAD;
            else if (div_cnt != '0)  div_cnt <= div_cnt - 1'b1;
            if (state == CAPTURE) begin
                shreg   <= cfg_data;
                bit_cnt <= LAST_BIT;
            end else if (state == SHIFT_HI && state_nx == SHIFT_LO) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    // Registered outputs, decoded from the state being entered so they line
    // up with the state they describe.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            cfg_rd          <= 1'b0;
            cfg_idx         <= '0;
            serial_clock    <= 1'b0;
            serial_data_out <= 1'b0;
            serial_load     <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            cfg_rd       <= (state_nx == FETCH);
            cfg_idx      <= pad_nx;
            serial_clock <= (state_nx == SHIFT_HI);
            serial_load  <= (state_nx == LOAD);
            busy         <= (state_nx != IDLE);
            done         <= (state_nx == DONE);
            // Data only moves on entry to the low phase, so it is stable
            // across the whole high phase and the falling transition.
            if (state == CAPTURE && state_nx == SHIFT_LO)
                serial_data_out <= cfg_data[CFG_BITS-1];
            else if (state == SHIFT_HI && state_nx == SHIFT_LO)
                serial_data_out <= shreg[CFG_BITS-2];
        end
    end

endmodule

// File: tb/tb_mprj_io_serial_loader.sv
// Directed bench for mprj_io_serial_loader: default load, divider, fetch
// protocol, abort, start-while-busy, start+abort, reset during LOAD.
module tb_mprj_io_serial_loader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default instance (19 pads, 13 bits, divider 1)
    logic        start0, abort0, rd0, sclk0, sdo0, load0, busy0, done0;
    logic [4:0]  idx0;
    logic [12:0] data0;
    // Divider instance (2 pads, 13 bits, divider 3)
    logic        start1, abort1, rd1, sclk1, sdo1, load1, busy1, done1;
    logic [0:0]  idx1;
    logic [12:0] data1;

    mprj_io_serial_loader #(.NUM_PADS(19), .CFG_BITS(13), .CLK_DIV(1)) dut0 (
        .wb_clk_i(clk), .wb_rstn_i(rst_n), .start(start0), .abort(abort0),
        .cfg_rd(rd0), .cfg_idx(idx0), .cfg_data(data0),
        .serial_clock(sclk0), .serial_data_out(sdo0), .serial_load(load0),
        .busy(busy0), .done(done0));

    mprj_io_serial_loader #(.NUM_PADS(2), .CFG_BITS(13), .CLK_DIV(3)) dut1 (
        .wb_clk_i(clk), .wb_rstn_i(rst_n), .start(start1), .abort(abort1),
        .cfg_rd(rd1), .cfg_idx(idx1), .cfg_data(data1),
        .serial_clock(sclk1), .serial_data_out(sdo1), .serial_load(load1),
        .busy(busy1), .done(done1));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Register file models: entry k = 13'h1000 | k, one cycle read latency
    always @(posedge clk) begin
        if (rd0) data0 <= 13'h1000 | 13'(idx0);
        if (rd1) data1 <= 13'h1000 | 13'(idx1);
    end

    // Chain models: shift on serial_clock rise, latch on serial_load
    logic [246:0] chain0, latched0;
    logic [25:0]  chain1, latched1;
    int rise0 = 0, rise1 = 0;
    always @(posedge sclk0) begin chain0 <= {chain0[245:0], sdo0}; rise0++; end
    always @(posedge sclk1) begin chain1 <= {chain1[24:0], sdo1}; rise1++; end
    always @(posedge clk) begin
        if (load0) latched0 <= chain0;
        if (load1) latched1 <= chain1;
    end

    // Protocol monitor for dut0
    int done_cnt0 = 0, load_cyc0 = 0, overlap = 0, rd_cnt0 = 0, rd_long0 = 0, idx_err0 = 0;
    int exp_idx0 = 18;
    logic rd_prev0 = 1'b0;
    always @(posedge clk) begin
        if (rst_n) begin
            if (!busy0 && start0) exp_idx0 = 18;
            if (rd0) begin
                if (32'(idx0) != exp_idx0) idx_err0++;
                exp_idx0--;
                rd_cnt0++;
                if (rd_prev0) rd_long0++;
            end
            if (done0) done_cnt0++;
            if (load0) load_cyc0++;
            if ((load0 && sclk0) || (load1 && sclk1)) overlap++;
        end
        rd_prev0 = rd0;
    end

    // Phase-length monitor for dut1: every high phase 3 cycles, every low
    // phase between bits of the same pad 3 cycles
    int done_cnt1 = 0, load_cyc1 = 0, ph_err = 0, hi = 0, lo = 0;
    logic p1 = 1'b0, rd_run = 1'b0;
    always @(posedge clk) begin
        if (sclk1 && !p1) begin
            if (!rd_run && lo != 3) ph_err++;
            hi = 1;
        end else if (sclk1) begin
            hi++;
        end else if (p1) begin
            if (hi != 3) ph_err++;
            lo = 1;
            rd_run = rd1;
        end else begin
            lo++;
            if (rd1) rd_run = 1'b1;
        end
        p1 = sclk1;
        if (done1) done_cnt1++;
        if (load1) load_cyc1++;
    end

    // Count edges after the start edge until done is seen (bounded);
    // optionally pulse start0 again at a given cycle.
    task automatic run_to_done(input int sel, input int pulse_at, output int n);
        n = 0;
        while (n <= 2000) begin
            @(posedge clk);
            #1;
            n++;
            if (sel == 0) start0 = (n == pulse_at);
            if ((sel == 0 && done0) || (sel == 1 && done1)) break;
        end
        start0 = 1'b0;
    endtask

    task automatic kick(input int sel);
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    int n, d0, l0, r0, c0, lg0;
    logic [31:0] expect_pad;

    initial begin
        rst_n = 1'b0;
        start0 = 0; abort0 = 0; start1 = 0; abort1 = 0;
        #22;
        // Reset state
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_cfg_rd", rd0, 0);
        chk("rst_cfg_idx", idx0, 0);
        chk("rst_sclk", sclk0, 0);
        chk("rst_sdo", sdo0, 0);
        chk("rst_load", load0, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Default load
        d0 = done_cnt0; r0 = rise0; c0 = rd_cnt0; lg0 = load_cyc0;
        kick(0);
        chk("fetch_cycle1_rd", rd0, 1);
        chk("fetch_cycle1_idx", idx0, 18);
        chk("busy_after_start", busy0, 1);
        run_to_done(0, -1, n);
        chk("done_latency", n, 533);
        repeat (5) @(posedge clk);
        #1;
        chk("done_once", done_cnt0 - d0, 1);
        chk("busy_idle", busy0, 0);
        chk("sclk_rises", rise0 - r0, 247);
        chk("cfg_rd_pulses", rd_cnt0 - c0, 19);
        chk("cfg_idx_order", idx_err0, 0);
        chk("cfg_rd_width", rd_long0, 0);
        chk("load_cycles", load_cyc0 - lg0, 1);
        for (int k = 0; k < 19; k++) begin
            expect_pad = 32'h1000 | k;
            chk($sformatf("pad%0d", k), 32'(latched0[k*13 +: 13]), expect_pad);
        end

        // Divider
        kick(1);
        run_to_done(1, -1, n);
        chk("div_done_latency", n, 163);
        repeat (3) @(posedge clk);
        #1;
        chk("div_done_once", done_cnt1, 1);
        chk("div_rises", rise1, 26);
        chk("div_phase_len", ph_err, 0);
        chk("div_load_len", load_cyc1, 3);
        chk("div_pad0", 32'(latched1[12:0]), 32'h1000);
        chk("div_pad1", 32'(latched1[25:13]), 32'h1001);

        // Abort during pad 10 SHIFT_HI
        d0 = done_cnt0; lg0 = load_cyc0;
        kick(0);
        n = 0;
        while (!(idx0 == 5'd10 && sclk0) && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_point_reached", (idx0 == 5'd10 && sclk0), 1);
        abort0 = 1'b1;
        @(posedge clk);
        #1;
        abort0 = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_sclk", sclk0, 0);
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt0 - d0, 0);
        chk("abort_no_load", load_cyc0 - lg0, 0);
        // Restart completes normally
        kick(0);
        run_to_done(0, -1, n);
        chk("restart_latency", n, 533);
        @(posedge clk);
        #1;
        chk("restart_pad18", 32'(latched0[18*13 +: 13]), 32'h1012);
        chk("restart_pad0", 32'(latched0[12:0]), 32'h1000);

        // Start while busy at cycle 100 is ignored
        d0 = done_cnt0;
        kick(0);
        run_to_done(0, 100, n);
        chk("busy_start_latency", n, 533);
        repeat (20) @(posedge clk);
        #1;
        chk("busy_start_single_done", done_cnt0 - d0, 1);
        chk("busy_start_idle", busy0, 0);

        // start and abort together in IDLE: start wins
        @(negedge clk);
        start0 = 1'b1;
        abort0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        abort0 = 1'b0;
        chk("start_abort_busy", busy0, 1);
        chk("start_abort_rd", rd0, 1);

        // Reset while serial_load is high
        n = 0;
        while (!load0 && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("load_seen", load0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_load", load0, 0);
        chk("async_rst_busy", busy0, 0);
        chk("async_rst_sclk", sclk0, 0);
        #6 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", busy0, 0);
        chk("post_rst_load", load0, 0);
        chk("post_rst_done", done0, 0);
        chk("post_rst_rd", rd0, 0);
        chk("post_rst_idx", idx0, 0);
        chk("post_rst_sdo", sdo0, 0);
        chk("overlap", overlap, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
